// File: rtl/apb_master_if.sv
// APB master: turns one host command into one APB setup/access transfer and
// returns exactly one response per command. The slave gets TIMEOUT_CYCLE
// access cycles to raise ready before the transfer is aborted with an error.
module apb_master_if #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLE  = 16
) (
    input  logic                          apb_clk_in,
    input  logic                          apb_rst_in,
    input  logic                          cmd_valid_in,
    output logic                          cmd_ready_out,
    input  logic [APB_ADDR_WIDTH-1:0]     cmd_addr_in,
    input  logic                          cmd_write_in,
    input  logic [APB_DATA_WIDTH-1:0]     cmd_wdata_in,
    input  logic [APB_DATA_WIDTH/8-1:0]   cmd_strb_in,
    input  logic [2:0]                    cmd_prot_in,
    output logic                          rsp_valid_out,
    input  logic                          rsp_ready_in,
    output logic [APB_DATA_WIDTH-1:0]     rsp_rdata_out,
    output logic                          rsp_error_out,
    output logic [APB_ADDR_WIDTH-1:0]     apb_addr_out,
    output logic                          apb_psel_out,
    output logic                          apb_penable_out,
    output logic                          apb_write_out,
    output logic [APB_DATA_WIDTH-1:0]     apb_wdata_out,
    output logic [APB_DATA_WIDTH/8-1:0]   apb_strb_out,
    output logic [2:0]                    apb_prot_out,
    input  logic [APB_DATA_WIDTH-1:0]     apb_rdata_in,
    input  logic                          apb_ready_in,
    input  logic                          apb_slverr_in
);

    localparam int STRB_W = APB_DATA_WIDTH / 8;
    // Wide enough to hold TIMEOUT_CYCLE; it stops at TIMEOUT_CYCLE-1 so never wraps.
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      write_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         strb_q;
    logic [2:0]                prot_q;
    logic                      rsp_valid_q;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                      rsp_error_q;

    // Transfer sequencer: command capture, setup/access phasing, timeout and response hold.
    always_ff @(posedge apb_clk_in) begin
        if (apb_rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            prot_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_in) begin
                        addr_q    <= cmd_addr_in;
                        write_q   <= cmd_write_in;
                        wdata_q   <= cmd_wdata_in;
                        // Reads never carry strobes onto the bus.
                        strb_q    <= cmd_write_in ? cmd_strb_in : '0;
                        prot_q    <= cmd_prot_in;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    // Ready from the slave is not meaningful before penable.
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (apb_ready_in) begin
                        rsp_error_q <= apb_slverr_in;
                        rsp_rdata_q <= (write_q || apb_slverr_in) ? '0 : apb_rdata_in;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        // Slave stalled for the full budget: abandon the transfer.
                        rsp_error_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_in) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_out   = (state_q == IDLE);
    assign rsp_valid_out   = rsp_valid_q;
    assign rsp_rdata_out   = rsp_rdata_q;
    assign rsp_error_out   = rsp_error_q;
    assign apb_addr_out    = addr_q;
    assign apb_psel_out    = psel_q;
    assign apb_penable_out = penable_q;
    assign apb_write_out   = write_q;
    assign apb_wdata_out   = wdata_q;
    assign apb_strb_out    = strb_q;
    assign apb_prot_out    = prot_q;

endmodule

// File: tb/tb_apb_master_if.sv
// Bench for apb_master_if: the bench plays host and APB slave, and predicts
// each transfer's length and response from the command and slave behaviour.
module tb_apb_master_if;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [AW-1:0] apb_addr;
    logic          apb_psel;
    logic          apb_penable;
    logic          apb_write;
    logic [DW-1:0] apb_wdata;
    logic [3:0]    apb_strb;
    logic [2:0]    apb_prot;
    logic [DW-1:0] apb_rdata;
    logic          apb_ready;
    logic          apb_slverr;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_if #(
        .APB_DATA_WIDTH(DW),
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLE (TO)
    ) dut (
        .apb_clk_in     (clk),
        .apb_rst_in     (rst),
        .cmd_valid_in   (cmd_valid),
        .cmd_ready_out  (cmd_ready),
        .cmd_addr_in    (cmd_addr),
        .cmd_write_in   (cmd_write),
        .cmd_wdata_in   (cmd_wdata),
        .cmd_strb_in    (cmd_strb),
        .cmd_prot_in    (cmd_prot),
        .rsp_valid_out  (rsp_valid),
        .rsp_ready_in   (rsp_ready),
        .rsp_rdata_out  (rsp_rdata),
        .rsp_error_out  (rsp_error),
        .apb_addr_out   (apb_addr),
        .apb_psel_out   (apb_psel),
        .apb_penable_out(apb_penable),
        .apb_write_out  (apb_write),
        .apb_wdata_out  (apb_wdata),
        .apb_strb_out   (apb_strb),
        .apb_prot_out   (apb_prot),
        .apb_rdata_in   (apb_rdata),
        .apb_ready_in   (apb_ready),
        .apb_slverr_in  (apb_slverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_psel"},    64'(apb_psel),    64'd0);
        chk({pfx, "_penable"}, 64'(apb_penable), 64'd0);
        chk({pfx, "_addr"},    64'(apb_addr),    64'd0);
        chk({pfx, "_write"},   64'(apb_write),   64'd0);
        chk({pfx, "_wdata"},   64'(apb_wdata),   64'd0);
        chk({pfx, "_strb"},    64'(apb_strb),    64'd0);
        chk({pfx, "_prot"},    64'(apb_prot),    64'd0);
        chk({pfx, "_rvalid"},  64'(rsp_valid),   64'd0);
        chk({pfx, "_rdata"},   64'(rsp_rdata),   64'd0);
        chk({pfx, "_rerror"},  64'(rsp_error),   64'd0);
    endtask

    // One complete command. waits = ACCESS cycles with ready low before the
    // slave answers; waits >= TO means the slave never answers. rdly = cycles
    // the host withholds rsp_ready while hammering cmd_valid.
    task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                           input logic [3:0] sb, input logic [2:0] pr, input int waits,
                           input logic serr, input logic [DW-1:0] rd, input int rdly);
        int            n_acc;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        logic [3:0]    exp_sb;
        int            lat;

        // Reference: response and transfer length from the bus rules.
        if (waits < TO) begin
            n_acc   = waits + 1;
            exp_err = serr;
            exp_rd  = (wr || serr) ? '0 : rd;
        end else begin
            n_acc   = TO;
            exp_err = 1'b1;
            exp_rd  = '0;
        end
        exp_sb = wr ? sb : 4'h0;

        @(negedge clk);
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_wdata = wd;
        cmd_strb  = sb;
        cmd_prot  = pr;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        // Scramble host inputs: bus must show the captured command.
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
        cmd_write = 1'($urandom);
        chk("setup_psel",    64'(apb_psel),    64'd1);
        chk("setup_penable", 64'(apb_penable), 64'd0);
        chk("setup_addr",    64'(apb_addr),    64'(addr));
        chk("setup_write",   64'(apb_write),   64'(wr));
        chk("setup_wdata",   64'(apb_wdata),   64'(wd));
        chk("setup_strb",    64'(apb_strb),    64'(exp_sb));
        chk("setup_prot",    64'(apb_prot),    64'(pr));
        chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
        // Slave noise during SETUP must be ignored.
        apb_ready  = 1'($urandom);
        apb_slverr = 1'($urandom);
        apb_rdata  = $urandom;
        @(posedge clk);
        @(negedge clk);
        lat++;
        chk("access_penable", 64'(apb_penable), 64'd1);
        chk("access_psel",    64'(apb_psel),    64'd1);
        chk("access_rvalid",  64'(rsp_valid),   64'd0);
        for (int i = 0; i < n_acc; i++) begin
            apb_ready  = (i == waits);
            apb_slverr = (i == waits) ? serr : 1'($urandom);
            apb_rdata  = (i == waits) ? rd : $urandom;
            @(posedge clk);
            @(negedge clk);
            lat++;
            apb_ready  = 1'b0;
            if (i < n_acc - 1) begin
                if (rsp_valid !== 1'b0 || apb_psel !== 1'b1 || apb_penable !== 1'b1) begin
                    chk("wait_rvalid",  64'(rsp_valid),   64'd0);
                    chk("wait_penable", 64'(apb_penable), 64'd1);
                end
                chk("wait_addr",  64'(apb_addr),  64'(addr));
                chk("wait_wdata", 64'(apb_wdata), 64'(wd));
                chk("wait_strb",  64'(apb_strb),  64'(exp_sb));
            end
        end
        // Response edge is 1 (SETUP) + n_acc edges after acceptance.
        chk("rsp_latency", 64'(rsp_valid ? lat : 0), 64'(1 + n_acc));
        chk("rsp_psel",    64'(apb_psel),    64'd0);
        chk("rsp_penable", 64'(apb_penable), 64'd0);
        chk("rsp_error",   64'(rsp_error),   64'(exp_err));
        chk("rsp_rdata",   64'(rsp_rdata),   64'(exp_rd));
        for (int j = 0; j < rdly; j++) begin
            cmd_valid = 1'b1;
            cmd_addr  = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("hold_rvalid",    64'(rsp_valid), 64'd1);
            chk("hold_rerror",    64'(rsp_error), 64'(exp_err));
            chk("hold_rdata",     64'(rsp_rdata), 64'(exp_rd));
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("hold_psel",      64'(apb_psel),  64'd0);
            chk("hold_addr",      64'(apb_addr),  64'(addr));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_rvalid",    64'(rsp_valid), 64'd0);
        chk("done_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("done_psel",      64'(apb_psel),  64'd0);
    endtask

    // Reset watchdog so a broken design cannot hang the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_write  = 1'b0;
        cmd_wdata  = '0;
        cmd_strb   = '0;
        cmd_prot   = '0;
        rsp_ready  = 1'b0;
        apb_rdata  = '0;
        apb_ready  = 1'b0;
        apb_slverr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

        // Directed cases.
        run_txn(32'h10, 1'b0, 32'h0, 4'hF, 3'd0, 0, 1'b0, 32'hDEADBEEF, 0);
        run_txn(32'h20, 1'b1, 32'hA5A5A5A5, 4'h3, 3'd2, 2, 1'b0, 32'h55AA55AA, 0);
        run_txn(32'h30, 1'b0, 32'h0, 4'hF, 3'd1, 0, 1'b1, 32'h1234, 0);
        run_txn(32'h40, 1'b0, 32'h0, 4'h0, 3'd0, TO, 1'b0, 32'h0, 0);
        run_txn(32'h44, 1'b1, 32'h600DF00D, 4'hC, 3'd7, TO - 1, 1'b0, 32'h0, 0);
        run_txn(32'h50, 1'b0, 32'h0, 4'hF, 3'd3, 1, 1'b0, 32'hCAFEF00D, 5);

        // Reset in the middle of an ACCESS phase.
        @(negedge clk);
        cmd_addr  = 32'h60;
        cmd_write = 1'b1;
        cmd_wdata = 32'h11223344;
        cmd_strb  = 4'hF;
        cmd_prot  = 3'd5;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        apb_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_penable", 64'(apb_penable), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < TO + 4; k++) begin
            apb_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid !== 1'b0 || apb_psel !== 1'b0)
                chk("midrst_no_rsp", 64'({rsp_valid, apb_psel}), 64'd0);
        end
        apb_ready = 1'b0;
        rsp_ready = 1'b0;
        chk("midrst_quiet", 64'({rsp_valid, apb_psel}), 64'd0);
        run_txn(32'h70, 1'b0, 32'h0, 4'hF, 3'd0, 0, 1'b0, 32'h87654321, 1);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            run_txn($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                    int'($urandom_range(0, TO + 3)), 1'($urandom_range(0, 3) == 0),
                    $urandom, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
